// File: rtl/frame_draw_scheduler.sv
// Per-frame render sequencer: scroll update, background draw, sprite draw.
// Ports: clock/resetn, frame_tick+scroll_*, bg_* and spr_* drawer handshakes
// and pixel buses, vga_* plot port, busy, frame_overrun.
// Optional macro FRAME_OVERRUN_CNT_EN adds overrun_count[7:0] (saturating).
module frame_draw_scheduler #(
    parameter int TILEMAP_LENGTH = 2000,
    parameter int SCREEN_TILES   = 20,
    parameter int SCROLL_STEP    = 1,
    parameter int COLOR_DEPTH    = 9
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic                   scroll_right,
    input  logic                   scroll_left,
    output logic                   bg_enable,
    input  logic                   bg_done,
    output logic [10:0]            x_tile_offset,
    output logic [2:0]             x_pixel_offset,
    input  logic [7:0]             bg_x,
    input  logic [6:0]             bg_y,
    input  logic [COLOR_DEPTH-1:0] bg_color,
    input  logic                   bg_plot,
    output logic                   spr_start,
    input  logic                   spr_done,
    input  logic [7:0]             spr_x,
    input  logic [6:0]             spr_y,
    input  logic [COLOR_DEPTH-1:0] spr_color,
    input  logic                   spr_plot,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [COLOR_DEPTH-1:0] vga_color,
    output logic                   vga_plot,
    output logic                   busy,
`ifdef FRAME_OVERRUN_CNT_EN
    output logic [7:0]             overrun_count,
`endif
    output logic                   frame_overrun
);

    localparam int MAX_POS = (TILEMAP_LENGTH - SCREEN_TILES) * 8;
    localparam logic [14:0] MAX_W  = 15'(MAX_POS);
    localparam logic [14:0] STEP_W = 15'(SCROLL_STEP);
    localparam logic [13:0] STEP_N = 14'(SCROLL_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCROLL,
        S_BG_START,
        S_BG_WAIT_LO,
        S_BG_WAIT_HI,
        S_SPR_START,
        S_SPR_WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [13:0]            pos_q, pos_d;
    logic                   right_q, right_d;
    logic                   left_q, left_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             x_q, x_d;
    logic [6:0]             y_q, y_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d;
    logic [14:0]            sum;

    assign sum = {1'b0, pos_q} + STEP_W;

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        right_d   = right_q;
        left_d    = left_q;
        overrun_d = frame_tick && (state_q != S_IDLE);
        bg_enable = 1'b0;
        spr_start = 1'b0;
        vga_plot  = 1'b0;
        vga_x     = x_q;
        vga_y     = y_q;
        vga_color = color_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    right_d = scroll_right;
                    left_d  = scroll_left;
                    state_d = S_SCROLL;
                end
            end
            S_SCROLL: begin
                if (right_q && !left_q) begin
                    pos_d = (sum > MAX_W) ? MAX_W[13:0] : sum[13:0];
                end else if (left_q && !right_q) begin
                    pos_d = (pos_q < STEP_N) ? 14'd0 : pos_q - STEP_N;
                end
                state_d = S_BG_START;
            end
            S_BG_START: begin
                bg_enable = 1'b1;
                state_d   = S_BG_WAIT_LO;
            end
            S_BG_WAIT_LO, S_BG_WAIT_HI: begin
                vga_plot  = bg_plot;
                vga_x     = bg_x;
                vga_y     = bg_y;
                vga_color = bg_color;
                // Drawer may still report idle on entry; wait for it to drop first.
                if (state_q == S_BG_WAIT_LO) begin
                    if (!bg_done) state_d = S_BG_WAIT_HI;
                end else if (bg_done) begin
                    state_d = S_SPR_START;
                end
            end
            S_SPR_START, S_SPR_WAIT: begin
                vga_plot  = spr_plot;
                vga_x     = spr_x;
                vga_y     = spr_y;
                vga_color = spr_color;
                if (state_q == S_SPR_START) begin
                    spr_start = 1'b1;
                    state_d   = S_SPR_WAIT;
                end else if (spr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        x_d     = vga_x;
        y_d     = vga_y;
        color_d = vga_color;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pos_q     <= '0;
            right_q   <= 1'b0;
            left_q    <= 1'b0;
            overrun_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            right_q   <= right_d;
            left_q    <= left_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
        end
    end

    assign x_tile_offset  = pos_q[13:3];
    assign x_pixel_offset = pos_q[2:0];
    assign busy           = (state_q != S_IDLE);
    assign frame_overrun  = overrun_q;

`ifdef FRAME_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_q && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) ovr_cnt_q <= '0;
        else         ovr_cnt_q <= ovr_cnt_d;
    end

    assign overrun_count = ovr_cnt_q;
`endif

endmodule
